// File: rtl/pin_game_pkg.sv
// Shared types and constants for the PIN guessing game controller.
package pin_game_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GEN     = 3'd1,
    ENTRY   = 3'd2,
    CHECK   = 3'd3,
    CLEAR   = 3'd4,
    WIN     = 3'd5,
    LOCKOUT = 3'd6
  } state_e;

  localparam logic [3:0]  DIGIT_MAX  = 4'd9;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam int          NUM_DIGITS = 4;

  // Lowest digit position whose match flag is clear; 0 when every digit matches.
  function automatic logic [1:0] first_wrong(input logic [3:0] match);
    first_wrong = 2'd0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (!match[i]) first_wrong = 2'(i);
    end
  endfunction

endpackage

// File: rtl/pin_game_controller_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used as the secret digit source.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] q
);
  import pin_game_pkg::*;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Shift left every cycle, feeding back the XOR of the tapped bits.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  end

  // State register; a nonzero seed keeps the sequence out of the all-zero lock-up state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/pin_game_controller.sv
// Sequencing controller for the 4-digit PIN guessing datapath: secret generation,
// guess entry, check rounds, attempt counting and timed lockout.
module pin_game_controller #(
  parameter int          MAX_ATTEMPTS   = 8,
  parameter int          LOCKOUT_CYCLES = 1000,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_enter,
  input  logic       btn_check,
  input  logic [3:0] digit_in,
  input  logic [3:0] digit_match,
  input  logic       all_correct,
  output logic       guess_wr_en,
  output logic       guess_clear_all,
  output logic       guess_clear_wrong,
  output logic [1:0] reg_sel,
  output logic       secret_wr_en,
  output logic [1:0] secret_sel,
  output logic [3:0] secret_digit,
  output logic [1:0] cursor,
  output logic [3:0] attempts_left,
  output logic       won,
  output logic       lost
);
  import pin_game_pkg::*;

  localparam int              LOCK_W        = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX    = LOCK_W'(LOCKOUT_CYCLES);
  localparam logic [3:0]      ATTEMPTS_INIT = 4'(MAX_ATTEMPTS);

  state_e            state_q, state_d;
  logic [1:0]        cursor_q, cursor_d;
  logic [3:0]        attempts_q, attempts_d;
  logic [1:0]        gen_idx_q, gen_idx_d;
  logic              gen_first_q, gen_first_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [4:0]        btn_q, btn_d;

  logic [4:0]  btn_pulse;
  logic        start_p, left_p, right_p, enter_p, check_p;
  logic        new_game;
  logic [15:0] lfsr;
  logic        lfsr_unused;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .q     (lfsr)
  );

  // Only the low nibble becomes a digit; the rest just carries the sequence.
  assign lfsr_unused = ^lfsr[15:4];

  // Rising-edge detection: a held button produces one pulse.
  always_comb begin
    btn_d     = {btn_check, btn_enter, btn_right, btn_left, start};
    btn_pulse = btn_d & ~btn_q;
    start_p   = btn_pulse[0];
    left_p    = btn_pulse[1];
    right_p   = btn_pulse[2];
    enter_p   = btn_pulse[3];
    check_p   = btn_pulse[4];
  end

  // Next-state and strobe logic; strobes fire in the same cycle as the causing pulse.
  always_comb begin
    state_d           = state_q;
    cursor_d          = cursor_q;
    attempts_d        = attempts_q;
    gen_idx_d         = gen_idx_q;
    gen_first_d       = gen_first_q;
    lock_cnt_d        = lock_cnt_q;
    guess_wr_en       = 1'b0;
    guess_clear_all   = 1'b0;
    guess_clear_wrong = 1'b0;
    secret_wr_en      = 1'b0;
    secret_digit      = 4'd0;
    new_game          = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_p) new_game = 1'b1;
      end
      GEN: begin
        guess_clear_all = gen_first_q;
        gen_first_d     = 1'b0;
        if (lfsr[3:0] <= DIGIT_MAX) begin
          secret_wr_en = 1'b1;
          secret_digit = lfsr[3:0];
          gen_idx_d    = gen_idx_q + 2'd1;
          if (gen_idx_q == 2'd3) state_d = ENTRY;
        end
      end
      ENTRY: begin
        if (check_p) begin
          state_d = CHECK;
        end else if (enter_p) begin
          if (digit_in <= DIGIT_MAX) guess_wr_en = 1'b1;
        end else if (right_p && !left_p) begin
          if (cursor_q != 2'd3) cursor_d = cursor_q + 2'd1;
        end else if (left_p && !right_p) begin
          if (cursor_q != 2'd0) cursor_d = cursor_q - 2'd1;
        end
      end
      CHECK: begin
        if (all_correct) begin
          state_d = WIN;
        end else if (attempts_q <= 4'd1) begin
          attempts_d = 4'd0;
          lock_cnt_d = '0;
          state_d    = LOCKOUT;
        end else begin
          attempts_d = attempts_q - 4'd1;
          state_d    = CLEAR;
        end
      end
      CLEAR: begin
        guess_clear_wrong = 1'b1;
        cursor_d          = first_wrong(digit_match);
        state_d           = ENTRY;
      end
      WIN: begin
        if (start_p) new_game = 1'b1;
      end
      LOCKOUT: begin
        attempts_d = 4'd0;
        if (lock_cnt_q != LOCK_MAX) lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        else if (start_p)           new_game   = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (new_game) begin
      state_d     = GEN;
      attempts_d  = ATTEMPTS_INIT;
      cursor_d    = 2'd0;
      gen_idx_d   = 2'd0;
      gen_first_d = 1'b1;
    end
  end

  // Controller registers; reset abandons any game in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cursor_q    <= 2'd0;
      attempts_q  <= 4'd0;
      gen_idx_q   <= 2'd0;
      gen_first_q <= 1'b0;
      lock_cnt_q  <= '0;
      btn_q       <= 5'd0;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      attempts_q  <= attempts_d;
      gen_idx_q   <= gen_idx_d;
      gen_first_q <= gen_first_d;
      lock_cnt_q  <= lock_cnt_d;
      btn_q       <= btn_d;
    end
  end

  assign reg_sel       = cursor_q;
  assign cursor        = cursor_q;
  assign secret_sel    = gen_idx_q;
  assign attempts_left = attempts_q;
  assign won           = (state_q == WIN);
  assign lost          = (state_q == LOCKOUT);

endmodule

// File: tb/tb_pin_game_controller.sv
// Directed self-checking bench for pin_game_controller.
module tb_pin_game_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_enter = 1'b0;
  logic       btn_check = 1'b0;
  logic [3:0] digit_in = 4'd0;
  logic [3:0] digit_match = 4'd0;
  logic       all_correct = 1'b0;
  logic       guess_wr_en, guess_clear_all, guess_clear_wrong;
  logic [1:0] reg_sel, secret_sel, cursor;
  logic       secret_wr_en, won, lost;
  logic [3:0] secret_digit, attempts_left;

  int vec_count = 0;
  int err_count = 0;

  logic [15:0] model_lfsr;
  logic [3:0]  first_digits [4];
  logic [3:0]  cur_digits   [4];

  pin_game_controller dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .btn_left          (btn_left),
    .btn_right         (btn_right),
    .btn_enter         (btn_enter),
    .btn_check         (btn_check),
    .digit_in          (digit_in),
    .digit_match       (digit_match),
    .all_correct       (all_correct),
    .guess_wr_en       (guess_wr_en),
    .guess_clear_all   (guess_clear_all),
    .guess_clear_wrong (guess_clear_wrong),
    .reg_sel           (reg_sel),
    .secret_wr_en      (secret_wr_en),
    .secret_sel        (secret_sel),
    .secret_digit      (secret_digit),
    .cursor            (cursor),
    .attempts_left     (attempts_left),
    .won               (won),
    .lost              (lost)
  );

  always #5 clock = ~clock;

  // Reference LFSR: taps 16,14,13,11, shifting left every cycle from the seed.
  always @(posedge clock or negedge reset) begin
    if (!reset) model_lfsr <= 16'hACE1;
    else        model_lfsr <= {model_lfsr[14:0],
                               model_lfsr[15] ^ model_lfsr[13] ^ model_lfsr[12] ^ model_lfsr[10]};
  end

  task automatic check_all_zero(input string name);
    logic [19:0] outs;
    outs = {guess_wr_en, guess_clear_all, guess_clear_wrong, reg_sel, secret_wr_en,
            secret_sel, secret_digit, cursor, attempts_left, won, lost};
    vec_count++;
    if (outs !== 20'd0) begin
      err_count++;
      $display("FAIL %s: outputs=%h expected 0", name, outs);
    end
  endtask

  task automatic press(input logic l, input logic r, input logic e, input logic c);
    @(negedge clock);
    btn_left = l; btn_right = r; btn_enter = e; btn_check = c;
    @(negedge clock);
    btn_left = 0; btn_right = 0; btn_enter = 0; btn_check = 0;
  endtask

  task automatic run_gen(input int stop_after);
    int writes;
    int cycles;
    int extra_clear;
    writes = 0; cycles = 0; extra_clear = 0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    vec_count++;
    if (guess_clear_all !== 1'b1) begin
      err_count++;
      $display("FAIL gen_clear_all_first: got %b expected 1", guess_clear_all);
    end
    vec_count++;
    if (attempts_left !== 4'd8 || cursor !== 2'd0 || won !== 1'b0 || lost !== 1'b0) begin
      err_count++;
      $display("FAIL gen_init: attempts=%0d cursor=%0d won=%b lost=%b expected 8/0/0/0",
               attempts_left, cursor, won, lost);
    end
    while (writes < stop_after && cycles < 200) begin
      if (cycles > 0 && guess_clear_all !== 1'b0) extra_clear++;
      vec_count++;
      if (secret_wr_en !== (model_lfsr[3:0] <= 4'd9)) begin
        err_count++;
        $display("FAIL gen_wr_en: got %b expected %b (lfsr nibble %0d)",
                 secret_wr_en, (model_lfsr[3:0] <= 4'd9), model_lfsr[3:0]);
      end
      if (secret_wr_en === 1'b1) begin
        vec_count++;
        if (secret_sel !== 2'(writes) || secret_digit !== model_lfsr[3:0]) begin
          err_count++;
          $display("FAIL gen_write: sel=%0d digit=%0d expected sel=%0d digit=%0d",
                   secret_sel, secret_digit, writes, model_lfsr[3:0]);
        end
        cur_digits[writes] = model_lfsr[3:0];
        writes++;
      end
      cycles++;
      if (writes < stop_after) @(negedge clock);
    end
    vec_count++;
    if (writes != stop_after) begin
      err_count++;
      $display("FAIL gen_timeout: writes=%0d expected %0d", writes, stop_after);
    end
    vec_count++;
    if (extra_clear != 0) begin
      err_count++;
      $display("FAIL gen_clear_all_once: extra pulses=%0d expected 0", extra_clear);
    end
  endtask

  task automatic check_fail(input logic [3:0] match, input logic [1:0] exp_cursor,
                            input logic [3:0] exp_att);
    logic [2:0] cw;
    digit_match = match; all_correct = 1'b0;
    @(negedge clock); btn_check = 1'b1;
    @(negedge clock); btn_check = 1'b0; cw[2] = guess_clear_wrong;
    @(negedge clock); cw[1] = guess_clear_wrong;
    vec_count++;
    if (attempts_left !== exp_att) begin
      err_count++;
      $display("FAIL fail_attempts: got %0d expected %0d", attempts_left, exp_att);
    end
    @(negedge clock); cw[0] = guess_clear_wrong;
    vec_count++;
    if (cw !== 3'b010) begin
      err_count++;
      $display("FAIL clear_wrong_pulse: got %b expected 010", cw);
    end
    vec_count++;
    if (cursor !== exp_cursor) begin
      err_count++;
      $display("FAIL clear_cursor: got %0d expected %0d", cursor, exp_cursor);
    end
  endtask

  task automatic test_reset;
    @(negedge clock); reset = 1'b0;
    #1;
    check_all_zero("reset_outputs");
    @(negedge clock); reset = 1'b1;
  endtask

  task automatic test_gen;
    run_gen(4);
    for (int i = 0; i < 4; i++) first_digits[i] = cur_digits[i];
    repeat (5) begin
      @(negedge clock);
      vec_count++;
      if (secret_wr_en !== 1'b0 || guess_clear_all !== 1'b0) begin
        err_count++;
        $display("FAIL gen_stops: wr_en=%b clear_all=%b expected 0/0", secret_wr_en, guess_clear_all);
      end
    end
    vec_count++;
    if (attempts_left !== 4'd8) begin
      err_count++;
      $display("FAIL entry_attempts: got %0d expected 8", attempts_left);
    end
  endtask

  task automatic test_cursor;
    logic [1:0] exp_r [5];
    logic [1:0] exp_l [5];
    exp_r = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    exp_l = '{2'd2, 2'd1, 2'd0, 2'd0, 2'd0};
    for (int i = 0; i < 5; i++) begin
      press(0, 1, 0, 0);
      vec_count++;
      if (cursor !== exp_r[i]) begin
        err_count++;
        $display("FAIL cursor_right: got %0d expected %0d", cursor, exp_r[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      press(1, 0, 0, 0);
      vec_count++;
      if (cursor !== exp_l[i]) begin
        err_count++;
        $display("FAIL cursor_left: got %0d expected %0d", cursor, exp_l[i]);
      end
    end
    press(0, 1, 0, 0);
    press(1, 1, 0, 0);
    vec_count++;
    if (cursor !== 2'd1) begin
      err_count++;
      $display("FAIL cursor_both: got %0d expected 1", cursor);
    end
  endtask

  task automatic test_enter;
    press(0, 1, 0, 0);
    digit_in = 4'd7;
    @(negedge clock); btn_enter = 1'b1;
    #1;
    vec_count++;
    if (guess_wr_en !== 1'b1 || reg_sel !== 2'd2) begin
      err_count++;
      $display("FAIL enter_valid: wr_en=%b reg_sel=%0d expected 1/2", guess_wr_en, reg_sel);
    end
    @(negedge clock);
    vec_count++;
    if (guess_wr_en !== 1'b0) begin
      err_count++;
      $display("FAIL enter_one_cycle: wr_en=%b expected 0", guess_wr_en);
    end
    btn_enter = 1'b0;
    digit_in = 4'd12;
    @(negedge clock); btn_enter = 1'b1;
    #1;
    vec_count++;
    if (guess_wr_en !== 1'b0) begin
      err_count++;
      $display("FAIL enter_invalid: wr_en=%b expected 0", guess_wr_en);
    end
    @(negedge clock); btn_enter = 1'b0;
    digit_in = 4'd5;
    @(negedge clock); btn_enter = 1'b1; btn_right = 1'b1;
    #1;
    vec_count++;
    if (guess_wr_en !== 1'b1 || reg_sel !== 2'd2) begin
      err_count++;
      $display("FAIL enter_with_move: wr_en=%b reg_sel=%0d expected 1/2", guess_wr_en, reg_sel);
    end
    @(negedge clock); btn_enter = 1'b0; btn_right = 1'b0;
    vec_count++;
    if (cursor !== 2'd2) begin
      err_count++;
      $display("FAIL enter_suppress_move: cursor=%0d expected 2", cursor);
    end
  endtask

  task automatic test_check_and_win;
    check_fail(4'b1010, 2'd0, 4'd7);
    check_fail(4'b0011, 2'd2, 4'd6);
    digit_match = 4'b1111; all_correct = 1'b1;
    @(negedge clock); btn_check = 1'b1;
    @(negedge clock); btn_check = 1'b0;
    @(negedge clock);
    vec_count++;
    if (won !== 1'b1 || lost !== 1'b0 || attempts_left !== 4'd6) begin
      err_count++;
      $display("FAIL win: won=%b lost=%b attempts=%0d expected 1/0/6", won, lost, attempts_left);
    end
    all_correct = 1'b0;
    run_gen(4);
  endtask

  task automatic test_lockout;
    for (int i = 1; i < 8; i++) check_fail(4'b0000, 2'd0, 4'(8 - i));
    digit_match = 4'b0000; all_correct = 1'b0;
    @(negedge clock); btn_check = 1'b1;
    @(negedge clock); btn_check = 1'b0;
    @(negedge clock);
    vec_count++;
    if (lost !== 1'b1 || attempts_left !== 4'd0 || guess_clear_wrong !== 1'b0) begin
      err_count++;
      $display("FAIL lockout_entry: lost=%b attempts=%0d clear_wrong=%b expected 1/0/0",
               lost, attempts_left, guess_clear_wrong);
    end
    repeat (10) @(negedge clock);
    start = 1'b1;
    @(negedge clock); start = 1'b0;
    vec_count++;
    if (lost !== 1'b1) begin
      err_count++;
      $display("FAIL lockout_early_start: lost=%b expected 1", lost);
    end
    repeat (988) @(negedge clock);
    start = 1'b1;
    @(negedge clock); start = 1'b0;
    vec_count++;
    if (lost !== 1'b1 || guess_clear_all !== 1'b0) begin
      err_count++;
      $display("FAIL lockout_start_at_999: lost=%b clear_all=%b expected 1/0", lost, guess_clear_all);
    end
    run_gen(4);
  endtask

  task automatic test_reset_mid_gen;
    test_reset();
    run_gen(2);
    #2 reset = 1'b0;
    #1;
    check_all_zero("mid_gen_reset");
    @(negedge clock); reset = 1'b1;
    run_gen(4);
    for (int i = 0; i < 4; i++) begin
      vec_count++;
      if (cur_digits[i] !== first_digits[i]) begin
        err_count++;
        $display("FAIL reseed_digit%0d: got %0d expected %0d", i, cur_digits[i], first_digits[i]);
      end
    end
  endtask

  initial begin
    $display("[TB] pin_game_controller bench starting");
    #3;
    test_reset();
    test_gen();
    test_cursor();
    test_enter();
    test_check_and_win();
    test_lockout();
    test_reset_mid_gen();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
